// File: rtl/ula_pkg.sv
// Shared types and constants for the ULA driver: op_sel encoding, FSM states, widths.
package ula_pkg;

    localparam int unsigned ULA_W_DEFAULT = 6;
    localparam int unsigned OP_W          = 3;
    localparam int unsigned CNT_W         = 4;
    localparam int unsigned OPCNT_W       = 8;

    typedef logic [OP_W-1:0] ula_op_t;

    localparam ula_op_t OP_AND  = 3'b000;
    localparam ula_op_t OP_OR   = 3'b001;
    localparam ula_op_t OP_XOR  = 3'b010;
    localparam ula_op_t OP_NOTA = 3'b011;
    localparam ula_op_t OP_NOTB = 3'b100;
    localparam ula_op_t OP_NAND = 3'b101;
    localparam ula_op_t OP_NOR  = 3'b110;
    localparam ula_op_t OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } drv_state_t;

endpackage

// File: rtl/ula_ref_model.sv
// Combinational golden model of the ULA logic mode; used only by the driver scoreboard.
module ula_ref_model
    import ula_pkg::*;
#(
    parameter int unsigned W = ULA_W_DEFAULT
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  ula_op_t      op_sel_i,
    output logic [W-1:0] exp_c,
    output logic         exp_carry_c,
    output logic         exp_zero_c
);

    always_comb begin
        exp_c = '0;
        case (op_sel_i)
            OP_AND:  exp_c = a_i & b_i;
            OP_OR:   exp_c = a_i | b_i;
            OP_XOR:  exp_c = a_i ^ b_i;
            OP_NOTA: exp_c = ~a_i;
            OP_NOTB: exp_c = ~b_i;
            OP_NAND: exp_c = ~(a_i & b_i);
            OP_NOR:  exp_c = ~(a_i | b_i);
            OP_XNOR: exp_c = ~(a_i ^ b_i);
            default: exp_c = '0;
        endcase
    end

    // Logic operations never produce a carry.
    assign exp_carry_c = 1'b0;
    assign exp_zero_c  = (exp_c == '0);

endmodule

// File: rtl/ula_driver.sv
// Command/result handshake driver for a combinational ULA with a settle delay.
// Define ULA_DRV_SCOREBOARD_EN to compile in the golden-model checker driving err.
module ula_driver
    import ula_pkg::*;
#(
    parameter int unsigned W      = ULA_W_DEFAULT,
    parameter int unsigned SETTLE = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [W-1:0]       cmd_a,
    input  logic [W-1:0]       cmd_b,
    input  logic               cmd_modo,
    input  logic [OP_W-1:0]    cmd_op_sel,
    output logic [W-1:0]       ula_a,
    output logic [W-1:0]       ula_b,
    output logic               ula_modo,
    output logic [OP_W-1:0]    ula_op_sel,
    input  logic [W-1:0]       ula_o,
    input  logic               ula_carry_out,
    input  logic               ula_zero,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [W-1:0]       res_o,
    output logic               res_carry,
    output logic               res_zero,
    output logic [OPCNT_W-1:0] op_count,
    output logic               err
);

    drv_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                last_q, last_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [W-1:0]        ula_a_q, ula_a_d;
    logic [W-1:0]        ula_b_q, ula_b_d;
    logic                ula_modo_q, ula_modo_d;
    ula_op_t             ula_op_q, ula_op_d;
    logic                res_valid_q, res_valid_d;
    logic [W-1:0]        res_o_q, res_o_d;
    logic                res_carry_q, res_carry_d;
    logic                res_zero_q, res_zero_d;
    logic [OPCNT_W-1:0]  op_count_q, op_count_d;
    logic                capture;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            last_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            ula_a_q     <= '0;
            ula_b_q     <= '0;
            ula_modo_q  <= 1'b0;
            ula_op_q    <= '0;
            res_valid_q <= 1'b0;
            res_o_q     <= '0;
            res_carry_q <= 1'b0;
            res_zero_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            cmd_ready_q <= cmd_ready_d;
            ula_a_q     <= ula_a_d;
            ula_b_q     <= ula_b_d;
            ula_modo_q  <= ula_modo_d;
            ula_op_q    <= ula_op_d;
            res_valid_q <= res_valid_d;
            res_o_q     <= res_o_d;
            res_carry_q <= res_carry_d;
            res_zero_q  <= res_zero_d;
            op_count_q  <= op_count_d;
        end
    end

    // Settle phase: count down SETTLE-1, then one extra cycle at zero before sampling.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        ula_a_d     = ula_a_q;
        ula_b_d     = ula_b_q;
        ula_modo_d  = ula_modo_q;
        ula_op_d    = ula_op_q;
        res_valid_d = res_valid_q;
        res_o_d     = res_o_q;
        res_carry_d = res_carry_q;
        res_zero_d  = res_zero_q;
        op_count_d  = op_count_q;
        capture     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    ula_a_d    = cmd_a;
                    ula_b_d    = cmd_b;
                    ula_modo_d = cmd_modo;
                    ula_op_d   = cmd_op_sel;
                    cnt_d      = CNT_W'(SETTLE - 1);
                    last_d     = 1'b0;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!last_q) begin
                    last_d = 1'b1;
                end else begin
                    capture     = 1'b1;
                    last_d      = 1'b0;
                    res_o_d     = ula_o;
                    res_carry_d = ula_carry_out;
                    res_zero_d  = ula_zero;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (res_valid_q && res_ready) begin
                    res_valid_d = 1'b0;
                    if (op_count_q != {OPCNT_W{1'b1}}) begin
                        op_count_d = op_count_q + OPCNT_W'(1);
                    end
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    assign cmd_ready  = cmd_ready_q;
    assign ula_a      = ula_a_q;
    assign ula_b      = ula_b_q;
    assign ula_modo   = ula_modo_q;
    assign ula_op_sel = ula_op_q;
    assign res_valid  = res_valid_q;
    assign res_o      = res_o_q;
    assign res_carry  = res_carry_q;
    assign res_zero   = res_zero_q;
    assign op_count   = op_count_q;

`ifdef ULA_DRV_SCOREBOARD_EN
    logic [W-1:0] exp_o;
    logic         exp_carry;
    logic         exp_zero;
    logic         mismatch_c;
    logic         err_q;

    ula_ref_model #(.W(W)) u_ref (
        .a_i         (ula_a_q),
        .b_i         (ula_b_q),
        .op_sel_i    (ula_op_q),
        .exp_c       (exp_o),
        .exp_carry_c (exp_carry),
        .exp_zero_c  (exp_zero)
    );

    assign mismatch_c = (ula_o != exp_o) || (ula_carry_out != exp_carry)
                     || (ula_zero != exp_zero);

    // Sticky until reset; only logic-mode captures are checked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (capture && ula_modo_q && mismatch_c) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ula_driver.sv
// Directed, table-driven bench for ula_driver with a behavioural ULA stand-in.
module tb_ula_driver;
    import ula_pkg::*;

    localparam int unsigned W = 6;

    logic         clk;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic         cmd_modo;
    logic [2:0]   cmd_op_sel;
    logic [W-1:0] ula_a;
    logic [W-1:0] ula_b;
    logic         ula_modo;
    logic [2:0]   ula_op_sel;
    logic [W-1:0] ula_o_s;
    logic         ula_carry_s;
    logic         ula_zero_s;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_o;
    logic         res_carry;
    logic         res_zero;
    logic [7:0]   op_count;
    logic         err;
    logic         fault;

    int passed;
    int total;

    ula_driver #(.W(W), .SETTLE(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_a         (cmd_a),
        .cmd_b         (cmd_b),
        .cmd_modo      (cmd_modo),
        .cmd_op_sel    (cmd_op_sel),
        .ula_a         (ula_a),
        .ula_b         (ula_b),
        .ula_modo      (ula_modo),
        .ula_op_sel    (ula_op_sel),
        .ula_o         (ula_o_s),
        .ula_carry_out (ula_carry_s),
        .ula_zero      (ula_zero_s),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_o         (res_o),
        .res_carry     (res_carry),
        .res_zero      (res_zero),
        .op_count      (op_count),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ULA stand-in; fault forces O bit0 stuck-at-1.
    always_comb begin
        ula_o_s = '0;
        if (ula_modo) begin
            case (ula_op_sel)
                3'b000:  ula_o_s = ula_a & ula_b;
                3'b001:  ula_o_s = ula_a | ula_b;
                3'b010:  ula_o_s = ula_a ^ ula_b;
                3'b011:  ula_o_s = ~ula_a;
                3'b100:  ula_o_s = ~ula_b;
                3'b101:  ula_o_s = ~(ula_a & ula_b);
                3'b110:  ula_o_s = ~(ula_a | ula_b);
                default: ula_o_s = ~(ula_a ^ ula_b);
            endcase
        end
        if (fault) ula_o_s[0] = 1'b1;
        ula_zero_s = (ula_o_s == '0);
    end
    assign ula_carry_s = 1'b0;

`ifdef ULA_DRV_SCOREBOARD_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Issue one command with res_ready high; returns result, latency and busy cycles.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                         input logic modo, output logic [W-1:0] o, output logic z,
                         output logic c, output int lat, output int busy);
        int guard;
        guard = 0;
        while (!cmd_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        cmd_a = a; cmd_b = b; cmd_op_sel = op; cmd_modo = modo;
        cmd_valid = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = -1; busy = 0; guard = 0;
        o = '0; z = 1'b0; c = 1'b0;
        while (!cmd_ready && guard < 60) begin
            busy++;
            if (res_valid && lat < 0) begin
                lat = guard; o = res_o; z = res_zero; c = res_carry;
            end
            @(posedge clk); #1; guard++;
        end
        res_ready = 1'b0;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic         modo;
        logic [W-1:0] exp_o;
        logic         exp_z;
    } vec_t;

    vec_t vecs[9];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] o;
        logic         z;
        logic         c;
        int           lat;
        int           busy;
        int           g;

        passed = 0; total = 0;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_modo = 1'b0; cmd_op_sel = '0;
        res_ready = 1'b0; fault = 1'b0;
        reset = 1'b0;

        vecs[0] = '{6'b000000, 6'b111111, OP_AND,  1'b1, 6'b000000, 1'b1};
        vecs[1] = '{6'b101010, 6'b010101, OP_OR,   1'b1, 6'b111111, 1'b0};
        vecs[2] = '{6'b101010, 6'b010101, OP_XOR,  1'b1, 6'b111111, 1'b0};
        vecs[3] = '{6'b111111, 6'b000000, OP_NOTA, 1'b1, 6'b000000, 1'b1};
        vecs[4] = '{6'b000000, 6'b001100, OP_NOTB, 1'b1, 6'b110011, 1'b0};
        vecs[5] = '{6'b110000, 6'b101000, OP_NAND, 1'b1, 6'b011111, 1'b0};
        vecs[6] = '{6'b110000, 6'b101000, OP_NOR,  1'b1, 6'b000111, 1'b0};
        vecs[7] = '{6'b110000, 6'b101000, OP_XNOR, 1'b1, 6'b100111, 1'b0};
        vecs[8] = '{6'b110011, 6'b101010, OP_OR,   1'b0, 6'b000000, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ula_a", 32'(ula_a), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Table: every operation plus a disabled-mode command, back-to-back.
        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].modo, o, z, c, lat, busy);
            check($sformatf("vec%0d_res_o", i), 32'(o), 32'(vecs[i].exp_o));
            check($sformatf("vec%0d_res_zero", i), 32'(z), 32'(vecs[i].exp_z));
            check($sformatf("vec%0d_res_carry", i), 32'(c), 32'd0);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'd3);
            check($sformatf("vec%0d_op_count", i), 32'(op_count), 32'(i + 1));
        end

        // Consumer stalls for 10 cycles while cmd_valid pulses.
        cmd_a = 6'b001111; cmd_b = 6'b110000; cmd_op_sel = OP_OR; cmd_modo = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        g = 0;
        while (!res_valid && g < 20) begin
            @(posedge clk); #1; g++;
        end
        check("hold_latency", 32'(g), 32'd2);
        for (int k = 0; k < 10; k++) begin
            cmd_valid = k[0];
            cmd_a = 6'b100001; cmd_b = 6'b000000; cmd_op_sel = OP_AND;
            @(posedge clk); #1;
            check($sformatf("hold%0d_res_o", k), 32'(res_o), 32'h3f);
            check($sformatf("hold%0d_res_valid", k), 32'(res_valid), 32'd1);
            check($sformatf("hold%0d_cmd_ready", k), 32'(cmd_ready), 32'd0);
            check($sformatf("hold%0d_ula_a", k), 32'(ula_a), 32'h0f);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("hold_consumed_valid", 32'(res_valid), 32'd0);
        check("hold_cmd_ready_after", 32'(cmd_ready), 32'd1);
        check("hold_op_count", 32'(op_count), 32'd10);
        repeat (3) @(posedge clk); #1;
        check("no_queue_cmd_ready", 32'(cmd_ready), 32'd1);
        check("no_queue_ula_a", 32'(ula_a), 32'h0f);

        // res_ready while idle is ignored.
        res_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        res_ready = 1'b0;
        check("idle_ready_op_count", 32'(op_count), 32'd10);
        check("idle_ready_res_valid", 32'(res_valid), 32'd0);

        // Stuck-at fault on O bit0 during NOT A of all-ones.
        fault = 1'b1;
        do_op(6'b111111, 6'b000000, OP_NOTA, 1'b1, o, z, c, lat, busy);
        fault = 1'b0;
        check("fault_res_o", 32'(o), 32'h01);
        check("fault_res_zero", 32'(z), 32'd0);
        check("fault_err", 32'(err), 32'(EXP_ERR));
        do_op(6'b111111, 6'b111111, OP_AND, 1'b1, o, z, c, lat, busy);
        check("after_fault_res_o", 32'(o), 32'h3f);
        check("after_fault_err_sticky", 32'(err), 32'(EXP_ERR));

        // Reset asserted mid-SETTLE clears everything before the next edge.
        cmd_a = 6'b110011; cmd_b = 6'b001100; cmd_op_sel = OP_XOR; cmd_modo = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("mid_settle_ula_a", 32'(ula_a), 32'h33);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_ula_a", 32'(ula_a), 32'd0);
        check("mid_rst_ula_b", 32'(ula_b), 32'd0);
        check("mid_rst_ula_modo", 32'(ula_modo), 32'd0);
        check("mid_rst_ula_op", 32'(ula_op_sel), 32'd0);
        check("mid_rst_res_o", 32'(res_o), 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cmd_a = 6'b010101; cmd_b = 6'b111111; cmd_op_sel = OP_AND; cmd_modo = 1'b1;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("first_accept_cmd_ready", 32'(cmd_ready), 32'd0);
        check("first_accept_ula_a", 32'(ula_a), 32'h15);
        res_ready = 1'b1;
        g = 0;
        while (!cmd_ready && g < 20) begin
            if (res_valid) check("first_accept_res_o", 32'(res_o), 32'h15);
            @(posedge clk); #1; g++;
        end
        res_ready = 1'b0;
        check("first_accept_op_count", 32'(op_count), 32'd1);

        // Saturation: 259 more operations, 260 in total since reset.
        for (int i = 2; i <= 260; i++) begin
            do_op(6'(i), 6'b111111, OP_AND, 1'b1, o, z, c, lat, busy);
            if (i == 254) check("sat_count_254", 32'(op_count), 32'd254);
        end
        check("sat_count_260", 32'(op_count), 32'd255);
        check("sat_err_clear", 32'(err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ula_driver.md
ULA_DRIVER -- requirements
Module: ula_driver

Interface
REQ-001 Parameter W, default 6: operand/result width; matches the ULA data width.
REQ-002 Parameter SETTLE, default 1 (range 1..15): clock cycles the ULA inputs are held stable before the result is sampled.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset.
REQ-005 cmd_valid  input  1: command present.
REQ-006 cmd_ready  output  1: driver accepts a command.
REQ-007 cmd_a, cmd_b  input  W: operands.
REQ-008 cmd_modo  input  1: 1 = logic mode, 0 = ULA disabled/other mode.
REQ-009 cmd_op_sel  input  3: operation select.
REQ-010 ula_a, ula_b  output  W: operands to the ULA.
REQ-011 ula_modo  output  1; ula_op_sel  output  3: mode and operation to the ULA.
REQ-012 ula_o  input  W; ula_carry_out  input  1; ula_zero  input  1: ULA combinational outputs.
REQ-013 res_valid  output  1: result available.
REQ-014 res_ready  input  1: consumer takes the result.
REQ-015 res_o  output  W; res_carry  output  1; res_zero  output  1: captured result.
REQ-016 op_count  output  8: number of completed operations.
REQ-017 err  output  1: sticky scoreboard mismatch flag.

Function
REQ-018 FSM states: IDLE, SETTLE, HOLD.
REQ-019 cmd_ready is 1 only in IDLE; a command is accepted on the edge where cmd_valid and cmd_ready are both 1.
REQ-020 On acceptance, cmd_a, cmd_b, cmd_modo, and cmd_op_sel are registered onto ula_* on that same edge; the FSM moves to SETTLE and loads the settle counter with SETTLE-1.
REQ-021 ula_* outputs remain constant from acceptance until the next acceptance.
REQ-022 SETTLE decrements the counter each cycle; when the counter is 0, the next edge captures ula_o, ula_carry_out, and ula_zero into the res_* registers, sets res_valid, and moves to HOLD.
REQ-023 Latency from acceptance to res_valid is exactly SETTLE+1 cycles; with SETTLE=1, res_valid rises 2 edges after acceptance.
REQ-024 In HOLD, res_* is stable; on res_valid and res_ready, res_valid clears, op_count increments, and the FSM returns to IDLE.
REQ-025 res_ready high while not in HOLD has no effect.
REQ-026 A new command cannot be accepted in the same cycle a result is consumed; cmd_ready rises on the cycle after consumption.
REQ-027 op_count saturates at 255 and does not wrap.
REQ-028 cmd_valid held high while cmd_ready is 0 is ignored; the command is not queued.

Reset
REQ-029 Reset assertion forces, immediately (including mid-operation): state IDLE, ula_a, ula_b, ula_op_sel 0, ula_modo 0, res_* 0, res_valid 0, op_count 0, err 0, settle counter 0.
REQ-030 The first acceptance after reset deassertion can occur on the first rising edge where reset is high.

Configuration
REQ-031 Macro ULA_DRV_SCOREBOARD_EN, when defined, compiles in a golden model that runs on every capture with ula_modo=1.
REQ-032 Golden model operations for op_sel 000..111: AND, OR, XOR, NOT A, NOT B, NAND, NOR, XNOR.
REQ-033 Golden model checks: carry = 0; zero = (expected O == 0).
REQ-034 Any mismatch on O, carry, or zero sets err, which holds until reset.
REQ-035 With ULA_DRV_SCOREBOARD_EN undefined, err is tied to 0 and no golden-model logic exists.

Structure
REQ-036 Shared package ula_pkg contains:
- the op_sel encoding as a 3-bit typedef plus named constants for the 8 operations;
- the FSM state typedef;
- the default width constant 6.
REQ-037 Sub-module ula_ref_model (combinational golden model) is instantiated only under ULA_DRV_SCOREBOARD_EN.

Verification
REQ-038 Scenario: reset low mid-SETTLE -> all outputs go to 0 before the next edge; cmd_ready is 1 after release.
REQ-039 Scenario: A=000000, B=111111, modo=1, op=000, SETTLE=1, ULA model connected -> res_valid on the 2nd edge after acceptance; res_o=000000, res_zero=1, res_carry=0.
REQ-040 Scenario: A=101010, B=010101, op=001, then op=010 back-to-back with res_ready=1 -> results 111111 then 111111; op_count=2; cmd_ready low for exactly 3 cycles per command.
REQ-041 Scenario: res_ready held 0 for 10 cycles -> res_* stable; cmd_ready=0; cmd_valid pulses ignored.
REQ-042 Scenario: scoreboard build, ULA model forcing O bit0 stuck-at-1 with op=011 and A=111111 -> err=1 after capture and remains 1 for later correct ops.
REQ-043 Scenario: 260 consumed operations -> op_count=255.
